// File: rtl/srl_rf_update_ctrl_if.sv
// rtl/srl_rf_update_ctrl_if.sv - rule-update request handshake between software side and the SRL update sequencer
interface srl_rf_update_ctrl_if #(
    parameter int COL_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [COL_W-1:0] req_col;
    logic             req_all;
    logic [4:0]       req_key;
    logic [4:0]       req_mask;
    logic             req_del;

    modport master (
        output req_valid,
        output req_col,
        output req_all,
        output req_key,
        output req_mask,
        output req_del,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_col,
        input  req_all,
        input  req_key,
        input  req_mask,
        input  req_del,
        output req_ready
    );
endinterface

// File: rtl/srl_rf_update_ctrl.sv
// rtl/srl_rf_update_ctrl.sv - serial shift sequencer writing one rule's 32-entry match vector into SRL32 columns
module srl_rf_update_ctrl #(
    parameter int NUM_COL = 8,
    parameter int COL_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    srl_rf_update_ctrl_if.slave  req,
    output logic                 srl_d,
    output logic [NUM_COL-1:0]   srl_ce,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Column count widened by one bit so an out-of-range index can be detected
    // even when NUM_COL equals 2**COL_W.
    localparam logic [COL_W:0] NUM_COL_EXT = (COL_W + 1)'(NUM_COL);

    state_t               state_q;
    state_t               state_d;
    logic                 accept;

    logic [4:0]           cnt_q;
    logic [4:0]           key_q;
    logic [4:0]           mask_q;
    logic                 del_q;
    logic [NUM_COL-1:0]   colmask_q;
    logic                 err_q;

    logic [COL_W-1:0]     col_in;
    logic [NUM_COL-1:0]   col_onehot;
    logic [NUM_COL-1:0]   colmask_d;
    logic                 col_oor;
    logic                 err_d;

    assign col_in = req.req_col;

    // Decode the requested column; an out-of-range index yields an empty mask.
    always_comb begin
        col_onehot = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            if (col_in == COL_W'(i)) begin
                col_onehot[i] = 1'b1;
            end
        end
    end

    assign col_oor   = ({1'b0, col_in} >= NUM_COL_EXT);
    assign colmask_d = req.req_all ? {NUM_COL{1'b1}} : col_onehot;
    assign err_d     = ~req.req_all & col_oor;

    // State register; reset wins over accept and over leaving DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, 32 shift cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture on accept and address countdown during the shift; the
    // counter wraps from 0 back to 31 so it is ready for the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 5'd31;
            key_q     <= 5'd0;
            mask_q    <= 5'd0;
            del_q     <= 1'b0;
            colmask_q <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= 5'd31;
            key_q     <= req.req_key;
            mask_q    <= req.req_mask;
            del_q     <= req.req_del;
            colmask_q <= colmask_d;
            err_q     <= err_d;
        end else if (state_q == ST_SHIFT) begin
            cnt_q     <= cnt_q - 5'd1;
        end
    end

    // Outputs come from registered state only, never from the req_* inputs.
    always_comb begin
        req.req_ready = (state_q == ST_IDLE);
        busy          = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done          = (state_q == ST_DONE);
        err           = (state_q == ST_DONE) & err_q;
        srl_ce        = '0;
        srl_d         = 1'b0;
        if (state_q == ST_SHIFT) begin
            srl_ce = colmask_q;
            srl_d  = ~del_q & (((cnt_q ^ key_q) & ~mask_q) == 5'd0);
        end
    end

endmodule

// File: tb/tb_srl_rf_update_ctrl.sv
// tb/tb_srl_rf_update_ctrl.sv - directed table-driven bench for srl_rf_update_ctrl
module tb_srl_rf_update_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       srl_d;
    logic [7:0] srl_ce;
    logic       busy;
    logic       done;
    logic       err;

    logic       srl_d6;
    logic [5:0] srl_ce6;
    logic       busy6;
    logic       done6;
    logic       err6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    srl_rf_update_ctrl_if #(.COL_W(3)) rif ();
    srl_rf_update_ctrl_if #(.COL_W(3)) rif6 ();

    srl_rf_update_ctrl #(.NUM_COL(8), .COL_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rif.slave),
        .srl_d  (srl_d),
        .srl_ce (srl_ce),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    srl_rf_update_ctrl #(.NUM_COL(6), .COL_W(3)) dut6 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rif6.slave),
        .srl_d  (srl_d6),
        .srl_ce (srl_ce6),
        .busy   (busy6),
        .done   (done6),
        .err    (err6)
    );

    // Behavioural SRL32 array: newest bit enters position 0.
    logic [31:0] srl_m [8];
    always @(posedge clk) begin
        for (int c = 0; c < 8; c++) begin
            if (srl_ce[c]) srl_m[c] <= {srl_m[c][30:0], srl_d};
        end
    end

    logic [31:0] exp_mem [8];
    logic [7:0]  exp_known = 8'h00;

    typedef struct {
        logic [2:0]  col;
        logic        all;
        logic [4:0]  key;
        logic [4:0]  mask;
        logic        del;
        logic [7:0]  exp_ce;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int c = 0; c < 8; c++) begin
            if (exp_known[c]) check($sformatf("%s mem col%0d", tag, c), srl_m[c], exp_mem[c]);
        end
    endtask

    // One full update: accept in cycle 0, shift 1..32, done 33, ready 34.
    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] dcap;
        int          ce_bad;
        @(negedge clk);
        check({tag, " ready c0"}, {31'd0, rif.req_ready}, 32'd1);
        rif.req_valid = 1'b1;
        rif.req_col   = v.col;
        rif.req_all   = v.all;
        rif.req_key   = v.key;
        rif.req_mask  = v.mask;
        rif.req_del   = v.del;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_col   = v.col + 3'd1;
        rif.req_all   = ~v.all;
        rif.req_key   = ~v.key;
        rif.req_mask  = ~v.mask;
        rif.req_del   = ~v.del;
        dcap   = '0;
        ce_bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            dcap[32-k] = srl_d;
            if (srl_ce !== v.exp_ce || busy !== 1'b1 || done !== 1'b0 || rif.req_ready !== 1'b0) ce_bad++;
        end
        check({tag, " ce/busy bad cycles"}, ce_bad, 0);
        check({tag, " d vector"}, dcap, v.exp_d);
        @(negedge clk);
        check({tag, " done c33"}, {31'd0, done}, 32'd1);
        check({tag, " err c33"}, {31'd0, err}, 32'd0);
        check({tag, " ce c33"}, {24'd0, srl_ce}, 32'd0);
        @(negedge clk);
        check({tag, " ready c34"}, {31'd0, rif.req_ready}, 32'd1);
        check({tag, " done c34"}, {31'd0, done}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (v.exp_ce[c]) begin
                exp_mem[c]   = v.exp_d;
                exp_known[c] = 1'b1;
            end
        end
        check_mem(tag);
    endtask

    initial begin
        logic [31:0] d1cap, d2cap;
        int          ce_bad, done_bad;

        vecs[0] = '{col: 3'd0, all: 1'b1, key: 5'h1F, mask: 5'h00, del: 1'b0, exp_ce: 8'hFF, exp_d: 32'h8000_0000};
        vecs[1] = '{col: 3'd3, all: 1'b0, key: 5'h0A, mask: 5'h00, del: 1'b0, exp_ce: 8'h08, exp_d: 32'h0000_0400};
        vecs[2] = '{col: 3'd0, all: 1'b0, key: 5'h10, mask: 5'h0F, del: 1'b0, exp_ce: 8'h01, exp_d: 32'hFFFF_0000};
        vecs[3] = '{col: 3'd5, all: 1'b1, key: 5'h0A, mask: 5'h00, del: 1'b1, exp_ce: 8'hFF, exp_d: 32'h0000_0000};
        vecs[4] = '{col: 3'd5, all: 1'b0, key: 5'h03, mask: 5'h18, del: 1'b0, exp_ce: 8'h20, exp_d: 32'h0808_0808};
        vecs[5] = '{col: 3'd7, all: 1'b0, key: 5'h15, mask: 5'h1F, del: 1'b0, exp_ce: 8'h80, exp_d: 32'hFFFF_FFFF};
        vecs[6] = '{col: 3'd1, all: 1'b0, key: 5'h1F, mask: 5'h01, del: 1'b0, exp_ce: 8'h02, exp_d: 32'hC000_0000};
        vecs[7] = '{col: 3'd2, all: 1'b0, key: 5'h00, mask: 5'h1F, del: 1'b1, exp_ce: 8'h04, exp_d: 32'h0000_0000};

        rif.req_valid  = 1'b1;
        rif.req_col    = 3'd3;
        rif.req_all    = 1'b0;
        rif.req_key    = 5'h0A;
        rif.req_mask   = 5'h00;
        rif.req_del    = 1'b0;
        rif6.req_valid = 1'b1;
        rif6.req_col   = 3'd1;
        rif6.req_all   = 1'b0;
        rif6.req_key   = 5'h00;
        rif6.req_mask  = 5'h00;
        rif6.req_del   = 1'b0;

        // Reset held 3 cycles with valid high: nothing may be accepted.
        rst_n = 1'b0;
        ce_bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rif.req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
                srl_ce !== 8'h00 || srl_d !== 1'b0 || busy6 !== 1'b0 || rif6.req_ready !== 1'b1) ce_bad++;
        end
        check("reset outputs bad cycles", ce_bad, 0);
        rif.req_valid  = 1'b0;
        rif6.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ready", {31'd0, rif.req_ready}, 32'd1);
        check("post-reset busy", {31'd0, busy}, 32'd0);

        // Reset during shift cycle 10 aborts without done.
        rif.req_valid = 1'b1;
        rif.req_col   = 3'd6;
        rif.req_all   = 1'b0;
        rif.req_key   = 5'h00;
        rif.req_mask  = 5'h1F;
        rif.req_del   = 1'b0;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset ce c10", {24'd0, srl_ce}, 32'h40);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset ce c11", {24'd0, srl_ce}, 32'd0);
        check("midreset ready c11", {31'd0, rif.req_ready}, 32'd1);
        done_bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_bad++;
        end
        check("midreset no done", done_bad, 0);
        exp_known[6] = 1'b0;

        // Table-driven updates.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back with valid held high; second request presented during the first shift.
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_col   = 3'd2;
        rif.req_all   = 1'b0;
        rif.req_key   = 5'h04;
        rif.req_mask  = 5'h00;
        rif.req_del   = 1'b0;
        @(posedge clk);
        #1;
        rif.req_col   = 3'd4;
        rif.req_key   = 5'h09;
        d1cap = '0;
        d2cap = '0;
        done_bad = 0;
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            if (k <= 32) d1cap[32-k] = srl_d;
            if (k >= 35 && k <= 66) d2cap[66-k] = srl_d;
            if (k == 33) begin
                check("b2b ce c33", {24'd0, srl_ce}, 32'd0);
                check("b2b done c33", {31'd0, done}, 32'd1);
            end else if (k == 34) begin
                check("b2b ce c34", {24'd0, srl_ce}, 32'd0);
                check("b2b ready c34", {31'd0, rif.req_ready}, 32'd1);
            end else if (k == 35) begin
                check("b2b ce c35", {24'd0, srl_ce}, 32'h10);
                rif.req_valid = 1'b0;
            end else if (k == 67) begin
                check("b2b done c67", {31'd0, done}, 32'd1);
            end else if (k == 68) begin
                check("b2b ready c68", {31'd0, rif.req_ready}, 32'd1);
            end else if (done !== 1'b0) begin
                done_bad++;
            end
        end
        check("b2b stray done", done_bad, 0);
        check("b2b d first", d1cap, 32'h0000_0010);
        check("b2b d second", d2cap, 32'h0000_0200);
        exp_mem[2] = 32'h0000_0010;
        exp_mem[4] = 32'h0000_0200;
        check_mem("b2b");

        // Six-column instance: out-of-range column runs the full sequence with no enables.
        @(negedge clk);
        rif6.req_valid = 1'b1;
        rif6.req_col   = 3'd7;
        rif6.req_all   = 1'b0;
        rif6.req_key   = 5'h00;
        rif6.req_mask  = 5'h1F;
        @(posedge clk);
        #1;
        rif6.req_valid = 1'b0;
        ce_bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (srl_ce6 !== 6'h00 || busy6 !== 1'b1) ce_bad++;
        end
        check("oor ce bad cycles", ce_bad, 0);
        @(negedge clk);
        check("oor done c33", {31'd0, done6}, 32'd1);
        check("oor err c33", {31'd0, err6}, 32'd1);
        @(negedge clk);
        check("oor err c34", {31'd0, err6}, 32'd0);
        check("oor ready c34", {31'd0, rif6.req_ready}, 32'd1);

        // Broadcast on the six-column instance ignores the bad index and raises no error.
        rif6.req_valid = 1'b1;
        rif6.req_all   = 1'b1;
        @(posedge clk);
        #1;
        rif6.req_valid = 1'b0;
        @(negedge clk);
        check("all6 ce c1", {26'd0, srl_ce6}, 32'h3F);
        for (int k = 2; k <= 33; k++) @(negedge clk);
        check("all6 done c33", {31'd0, done6}, 32'd1);
        check("all6 err c33", {31'd0, err6}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/srl_rf_update_ctrl.md
# srl_rf_update_ctrl

Update sequencer for the SRL32 rule-storage array in the fractcam update logic. It accepts one rule-update request at a time: a target column, a 5-bit key slice, a don't-care mask and a delete flag. It then serially shifts the 32-entry match vector for that rule into the selected SRL column or columns, driving the shared `d` line and the per-column `ce` lines of the SRL array. Lookups read the SRLs through their address inputs. This block owns only the write/shift side.

## Interface
- `NUM_COL`, default 8: number of SRL columns driven; range 1..8.
- `COL_W`, default 3: width of the column index; must satisfy `2**COL_W >= NUM_COL`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: update request valid.
- `req_ready` out 1: controller can accept a request; high only in IDLE.
- `req_col` in `COL_W`: target column index.
- `req_all` in 1: broadcast to all columns; `req_col` is ignored.
- `req_key` in 5: key slice for the rule.
- `req_mask` in 5: don't-care mask; bit = 1 means the key bit is ignored.
- `req_del` in 1: delete; shift all-zero into the target.
- `srl_d` out 1: serial data to the SRL array.
- `srl_ce` out `NUM_COL`: per-column shift enable.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: one-cycle pulse when the update completes.
- `err` out 1: one-cycle pulse with `done` when `req_col >= NUM_COL` and `req_all = 0`.

## Operation
- **FSM states.**
  - IDLE: `req_ready = 1`.
  - SHIFT: 32 cycles.
  - DONE: 1 cycle.
- **IDLE → SHIFT** on `req_valid & req_ready`. On that edge the controller latches:
  - `key`, `mask`, `del`;
  - the column mask: one-hot of `req_col`, or all-ones if `req_all`, or zero if the column is out of range;
  - the error flag;
  - `cnt = 31`.
- **SHIFT.**
  - `srl_ce` = latched column mask; `cnt` decrements every cycle.
  - At `cnt == 0` the FSM moves to DONE on the next edge.
- **DONE.** `done = 1`, `err` = latched error flag, `srl_ce = 0`; returns to IDLE on the next edge.
- **Data.**
  - `srl_d = ~del & (((cnt ^ key) & ~mask) == 0)`.
  - The bit for address 31 is shifted first, so after 32 shifts SRL position A holds the match result for address A.
- **Outputs outside SHIFT.** `srl_ce = 0` and `srl_d = 0`.
- **Output logic.** `srl_ce` and `srl_d` are decoded from registered state only, with no combinational path from the `req_*` inputs.
- **Request inputs.** `req_*` is sampled only on the accept edge. Changes during SHIFT have no effect.
- **Out-of-range column.** The request is still accepted and the full 34-cycle sequence runs with `srl_ce = 0`; DONE pulses `err`.
- **Reset.** Reset mid-operation forces IDLE on the next edge. A partially shifted column keeps corrupt contents and is not flagged; software re-issues the update.

## Timing
- **Reset values:**
  - `req_ready = 1`, `busy = 0`, `done = 0`, `err = 0`, `srl_ce = 0`, `srl_d = 0`;
  - `cnt = 31`, state IDLE.
- **Cycle numbering.** Accept edge at cycle 0; shift cycles are cycles 1..32, each with `srl_ce` high.
  - Cycle k presents the data bit for address `32 - k`.
  - `done`/`err` are high in cycle 33.
  - `req_ready` is high again in cycle 34.
- **Throughput.** One update per 34 cycles. With `req_valid` held high, back-to-back requests are accepted at cycles 0, 34, 68, …
- **`busy`.** High in cycles 1..33.
- **Simultaneous events.** `rst_n = 0` takes priority over every transition, including accept and DONE.

## Test plan
- **Reset.** Hold `rst_n = 0` for 3 cycles with `req_valid = 1` → no accept; all outputs at their reset values; `req_ready = 1` after release.
- **Exact-match write.** `req_col = 3`, `key = 5'h0A`, `mask = 0` → `srl_ce = 8'h08` for cycles 1..32, `srl_d = 1` only in cycle 22. In the SRL model, reading address 10 of column 3 returns 1 and every other address returns 0. `done` pulses in cycle 33 with `err = 0`.
- **Wildcard.** `key = 5'h10`, `mask = 5'h0F`, `col = 0` → `srl_d = 1` in cycles 1..16 (addresses 31..16) and 0 in cycles 17..32.
- **Broadcast delete.** `req_all = 1`, `req_del = 1` → `srl_ce = 8'hFF` and `srl_d = 0` for 32 cycles; all columns read 0 afterwards.
- **Back-to-back.** `req_valid` held high with two queued requests → second accept at cycle 34; no `srl_ce` in cycles 33–34; `done` pulses at 33 and 67.
- **Error and reset.**
  - With `NUM_COL = 6`, `req_col = 7` → `srl_ce = 0` throughout; `done` and `err` both pulse in cycle 33.
  - Separately, assert reset during shift cycle 10 → `srl_ce = 0` and `req_ready = 1` from the next cycle; no `done`.
